// File: rtl/twenty_bit_subtractor.sv
// Purpose: registered 20-bit unsigned subtractor, d = (i0 - i1) mod 2^20, bout = (i0 < i1).
// Latency: one cycle; operands stable before edge N appear on d/bout after edge N.
// Backpressure: none; a new result is captured on every rising edge, no handshake.

// Half subtractor: difference and borrow of a - b.
module twenty_bit_subtractor_hs (
    input  logic a_i,
    input  logic b_i,
    output logic diff_o,
    output logic borrow_o
);
    assign diff_o   = a_i ^ b_i;
    assign borrow_o = ~a_i & b_i;
endmodule

// Full subtractor: two half subtractors chained through the borrow-in,
// with the two partial borrows ORed. The second stage's borrow reduces to
// ~(a ^ b) & bin, so the OR gives the usual ripple-borrow equation.
module twenty_bit_subtractor_fs (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);
    logic d1;
    logic b1;
    logic b2;

    twenty_bit_subtractor_hs u_hs_ab (
        .a_i      (a_i),
        .b_i      (b_i),
        .diff_o   (d1),
        .borrow_o (b1)
    );

    twenty_bit_subtractor_hs u_hs_bin (
        .a_i      (d1),
        .b_i      (bin_i),
        .diff_o   (diff_o),
        .borrow_o (b2)
    );

    assign bout_o = b1 | b2;
endmodule

// Top: ripple-borrow chain of 20 full-subtractor cells feeding the output register.
module twenty_bit_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] i0,
    input  logic [19:0] i1,
    output logic [19:0] d,
    output logic        bout
);
    // borrow[k] is the borrow into cell k; borrow[20] leaves the MSB cell.
    logic [20:0] borrow;
    logic [19:0] diff;

    logic [19:0] d_q;
    logic [19:0] d_d;
    logic        bout_q;
    logic        bout_d;

    // No borrow-in port: the LSB cell always starts from zero.
    assign borrow[0] = 1'b0;

    for (genvar k = 0; k < 20; k++) begin : g_cell
        twenty_bit_subtractor_fs u_fs (
            .a_i    (i0[k]),
            .b_i    (i1[k]),
            .bin_i  (borrow[k]),
            .diff_o (diff[k]),
            .bout_o (borrow[k+1])
        );
    end

    // Next-state of the output register is the settled ripple result.
    always_comb begin
        d_d    = diff;
        bout_d = borrow[20];
    end

    // Capture {bout, d} every edge; reset wins over the operands at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= 20'h00000;
            bout_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            bout_q <= bout_d;
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_twenty_bit_subtractor.sv
module tb_twenty_bit_subtractor;
    logic        clk;
    logic        rst;
    logic [19:0] i0;
    logic [19:0] i1;
    logic [19:0] d;
    logic        bout;

    int errors = 0;
    int checks = 0;

    twenty_bit_subtractor dut (
        .clk  (clk),
        .rst  (rst),
        .i0   (i0),
        .i1   (i1),
        .d    (d),
        .bout (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] exp_d, input logic exp_b);
        checks++;
        assert ({bout, d} === {exp_b, exp_d})
        else begin
            errors++;
            $error("FAIL %s observed bout=%0b d=%05h expected bout=%0b d=%05h",
                   tag, bout, d, exp_b, exp_d);
        end
    endtask

    // Present operands away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic r, input logic [19:0] a, input logic [19:0] b);
        rst = r;
        i0  = a;
        i1  = b;
        @(posedge clk);
        #1;
    endtask

    logic [20:0] ref_val;
    logic [19:0] ra;
    logic [19:0] rb;
    logic [19:0] held_d;
    logic        held_b;

    initial begin
        rst = 1'b1;
        i0  = 20'd0;
        i1  = 20'd0;
        @(negedge clk);

        // Reset held for two edges with live operands.
        step(1'b1, 20'd72, 20'd27);
        chk("reset_edge1", 20'h00000, 1'b0);
        step(1'b1, 20'd72, 20'd27);
        chk("reset_edge2", 20'h00000, 1'b0);
        step(1'b0, 20'd72, 20'd27);
        chk("after_release_72m27", 20'd45, 1'b0);

        // Basic cases.
        step(1'b0, 20'd0, 20'd0);
        chk("0m0", 20'd0, 1'b0);
        step(1'b0, 20'd0, 20'd1);
        chk("0m1_full_ripple", 20'hFFFFF, 1'b1);
        step(1'b0, 20'd1, 20'd0);
        chk("1m0", 20'd1, 1'b0);
        step(1'b0, 20'd110, 20'd110);
        chk("110m110", 20'd0, 1'b0);
        step(1'b0, 20'd72, 20'd27);
        chk("72m27", 20'd45, 1'b0);

        // Extremes.
        step(1'b0, 20'hFFFFF, 20'd0);
        chk("max_m0", 20'hFFFFF, 1'b0);
        step(1'b0, 20'd0, 20'hFFFFF);
        chk("0_mmax", 20'd1, 1'b1);
        step(1'b0, 20'h80000, 20'd1);
        chk("msb_m1", 20'h7FFFF, 1'b0);
        step(1'b0, 20'hFFFFF, 20'hFFFFF);
        chk("max_mmax", 20'd0, 1'b0);

        // Outputs hold between edges while operands toggle.
        held_d = 20'h7FFFF;
        held_b = 1'b0;
        step(1'b0, 20'h80000, 20'd1);
        i0 = 20'd3;
        i1 = 20'd9;
        #2;
        chk("hold_between_edges", held_d, held_b);

        // Reset mid-stream discards the operands at that edge.
        step(1'b1, 20'd5, 20'd9);
        chk("mid_reset", 20'd0, 1'b0);
        step(1'b0, 20'd5, 20'd9);
        chk("after_mid_reset_5m9", 20'hFFFFC, 1'b1);

        // Random pairs, each checked exactly one edge after presentation.
        for (int n = 0; n < 10000; n++) begin
            ra = 20'($urandom);
            rb = 20'($urandom);
            ref_val = {1'b0, ra} - {1'b0, rb};
            step(1'b0, ra, rb);
            chk("random", ref_val[19:0], ref_val[20]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
